// File: rtl/pfifo_pkg.sv
// pfifo_pkg: shared constants and elaboration-time helpers for the pfifo block.
//   MODE_ZL  : zero-latency (combinational) read path
//   MODE_REG : registered read path, one cycle of latency
//   params_ok: legality check on DEPTH / AF_TH / AE_TH
package pfifo_pkg;

    localparam int unsigned MODE_ZL  = 0;
    localparam int unsigned MODE_REG = 1;

    // DEPTH must be a power of two, at least 4, and 0 < ae_th < af_th <= depth.
    function automatic bit params_ok(input int unsigned depth,
                                     input int unsigned af_th,
                                     input int unsigned ae_th);
        bit pow2;
        pow2 = (depth != 0) && ((depth & (depth - 1)) == 0);
        return pow2 && (depth >= 4) && (ae_th > 0) && (ae_th < af_th) && (af_th <= depth);
    endfunction

endpackage

// File: rtl/pfifo_ram.sv
// pfifo_ram: DEPTH x WIDTH storage array for pfifo.
//   clk   : write clock
//   we    : write enable; waddr/wdata written on posedge clk
//   raddr : asynchronous read address; rdata is mem[raddr]
// Contents are intentionally not reset.
module pfifo_ram #(
    parameter int unsigned  WIDTH = 16,
    parameter int unsigned  DEPTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pfifo.sv
// pfifo: synchronous FIFO with status flags, sticky error flags and a selectable read path.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : clears contents (pointers to 0) on the next edge
//   push, wdata, ack  : write request, data, and accepted-this-cycle
//   pop, rdata, valid : read request, data, and data qualifier
//   err_clr           : clears overflow/underflow (a same-cycle set wins)
//   full, empty, al_full, al_empty, count : occupancy status from the pointers
//   overflow, underflow : sticky error flags
// MODE_ZL reads combinationally (with optional empty-FIFO bypass); MODE_REG registers the read.
module pfifo
    import pfifo_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned AF_TH  = DEPTH - 2,
    parameter int unsigned AE_TH  = 2,
    parameter int unsigned MODE   = MODE_ZL,
    parameter int unsigned BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       rdata,
    output logic                   valid,
    output logic                   ack,
    output logic                   full,
    output logic                   empty,
    output logic                   al_full,
    output logic                   al_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] DepthCnt = PW'(DEPTH);
    localparam logic [PW-1:0] AfCnt    = PW'(AF_TH);
    localparam logic [PW-1:0] AeCnt    = PW'(AE_TH);

    if (!params_ok(DEPTH, AF_TH, AE_TH)) begin : g_bad_params
        $fatal(1, "pfifo: illegal DEPTH/AF_TH/AE_TH combination");
    end

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic             overflow_q, underflow_q;
    logic             wen, ren, bypass, ram_we;
    logic             ovf_set, udf_set;
    logic [WIDTH-1:0] ram_rdata;

    // Pointers carry a wrap bit, so the modular difference is the occupancy.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (count == '0);
    assign full     = (count == DepthCnt);
    assign al_full  = (count >= AfCnt);
    assign al_empty = (count <= AeCnt);

    always_comb begin
        bypass  = (MODE == MODE_ZL) && (BYPASS != 0) && empty && push && pop && !flush && !rst;
        wen     = push && !flush && !rst && (!full || pop);
        ren     = pop && !flush && !rst && !empty;
        // Bypassed data goes straight to rdata, so nothing is stored.
        ram_we  = wen && !bypass;
        ovf_set = push && !wen && !flush;
        udf_set = pop && !ren && !bypass && !flush;
    end

    assign ack       = wen;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (ram_we) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (ren)    rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= ovf_set || (overflow_q && !err_clr);
            underflow_q <= udf_set || (underflow_q && !err_clr);
        end
    end

    pfifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    if (MODE == MODE_REG) begin : g_reg_read
        logic [WIDTH-1:0] rdata_q;
        logic             valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= ren;
                if (ren) rdata_q <= ram_rdata;
            end
        end

        assign rdata = rdata_q;
        assign valid = valid_q;
    end else begin : g_zl_read
        assign valid = ren || bypass;
        assign rdata = rst ? '0 : (bypass ? wdata : ram_rdata);
    end

endmodule

// File: tb/tb_pfifo.sv
// tb_pfifo: drives a MODE 0 and a MODE 1 pfifo (WIDTH=8, DEPTH=8, AF_TH=6, AE_TH=2) with the
// same stimulus. A queue-based reference model per mode predicts status/ack each cycle and
// pushes expected read data (with the cycle it must appear in) into a scoreboard; a separate
// monitor pops and compares whenever a DUT asserts valid.
module tb_pfifo;

    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    typedef logic [7:0] data_t;
    typedef struct {
        data_t d;
        int    cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush, push, pop, err_clr;
    data_t      wdata;
    logic [1:0][7:0] rdata;
    logic [1:0][3:0] count;
    logic [1:0] valid, ack, full, empty, al_full, al_empty, overflow, underflow;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    data_t mq0[$], mq1[$];
    bit    ovf_m[2], udf_m[2];
    exp_t  eq0[$], eq1[$];

    pfifo #(.WIDTH(8), .DEPTH(D), .AF_TH(AF), .AE_TH(AE), .MODE(0), .BYPASS(1)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .wdata(wdata), .pop(pop),
        .err_clr(err_clr), .rdata(rdata[0]), .valid(valid[0]), .ack(ack[0]), .full(full[0]),
        .empty(empty[0]), .al_full(al_full[0]), .al_empty(al_empty[0]), .count(count[0]),
        .overflow(overflow[0]), .underflow(underflow[0])
    );

    pfifo #(.WIDTH(8), .DEPTH(D), .AF_TH(AF), .AE_TH(AE), .MODE(1), .BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .wdata(wdata), .pop(pop),
        .err_clr(err_clr), .rdata(rdata[1]), .valid(valid[1]), .ack(ack[1]), .full(full[1]),
        .empty(empty[1]), .al_full(al_full[1]), .al_empty(al_empty[1]), .count(count[1]),
        .overflow(overflow[1]), .underflow(underflow[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus. Entered and left at posedge+1.
    task automatic cycle(input bit r, input bit f, input bit p, input bit pp, input bit ec,
                         input data_t wd);
        logic [1:0][10:0] exp_st;
        rst = r; flush = f; push = p; pop = pp; err_clr = ec; wdata = wd;
        for (int m = 0; m < 2; m++) begin
            data_t q[$];
            bit ov, ud, emp, ful, byp, wen, ren;
            int n;
            if (m == 0) q = mq0; else q = mq1;
            ov  = ovf_m[m];
            ud  = udf_m[m];
            n   = q.size();
            emp = (n == 0);
            ful = (n == D);
            byp = (m == 0) && emp && p && pp && !f && !r;
            wen = p && !f && !r && (!ful || pp);
            ren = pp && !f && !r && !emp;
            exp_st[m] = {wen, ful, emp, n >= AF, n <= AE, ov, ud, 4'(n)};
            // Expected read data: same cycle in MODE 0, next cycle in MODE 1.
            if (ren || byp) begin
                exp_t e;
                e.d   = byp ? wd : q[0];
                e.cyc = cyc + m;
                if (m == 0) eq0.push_back(e); else eq1.push_back(e);
            end
            if (r) begin
                q.delete();
                ov = 1'b0;
                ud = 1'b0;
            end else begin
                ov = (p && !wen && !f) || (ov && !ec);
                ud = (pp && !ren && !byp && !f) || (ud && !ec);
                if (f) begin
                    q.delete();
                end else if (!byp) begin
                    if (ren) void'(q.pop_front());
                    if (wen) q.push_back(wd);
                end
            end
            if (m == 0) mq0 = q; else mq1 = q;
            ovf_m[m] = ov;
            udf_m[m] = ud;
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("status{ack,full,empty,afull,aempty,ovf,udf,count} mode%0d", m),
                32'({ack[m], full[m], empty[m], al_full[m], al_empty[m], overflow[m],
                     underflow[m], count[m]}), 32'(exp_st[m]));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            exp_t e;
            bit   have;
            have = (m == 0) ? (eq0.size() > 0) : (eq1.size() > 0);
            if (have) e = (m == 0) ? eq0[0] : eq1[0];
            if (valid[m] === 1'b1) begin
                if (!have) begin
                    chk($sformatf("unexpected valid mode%0d", m), 32'(valid[m]), 32'd0);
                end else begin
                    if (m == 0) void'(eq0.pop_front()); else void'(eq1.pop_front());
                    chk($sformatf("rdata mode%0d", m), 32'(rdata[m]), 32'(e.d));
                    chk($sformatf("read cycle mode%0d", m), 32'(cyc), 32'(e.cyc));
                end
            end else if (have && e.cyc <= cyc) begin
                if (m == 0) void'(eq0.pop_front()); else void'(eq1.pop_front());
                chk($sformatf("missing valid mode%0d", m), 32'(valid[m]), 32'd1);
            end
        end
    end

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        cycle(1, 0, 1, 1, 1, 8'hFF);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset rdata mode1", 32'(rdata[1]), 32'd0);

        // Fill to full, overflow, overflow again with err_clr, then clear, then drain.
        for (int i = 1; i <= 8; i++) cycle(0, 0, 1, 0, 0, 8'(i));
        cycle(0, 0, 1, 0, 0, 8'h09);
        cycle(0, 0, 1, 0, 1, 8'h0A);
        cycle(0, 0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0, 8'h00);
        idle();

        // Push and pop together on empty: bypass in MODE 0, store + underflow in MODE 1.
        cycle(0, 0, 1, 1, 0, 8'hA5);
        idle();
        cycle(0, 1, 0, 0, 1, 8'h00);
        idle();

        // Two entries, three pops.
        cycle(0, 0, 1, 0, 0, 8'h11);
        cycle(0, 0, 1, 0, 0, 8'h22);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 8'h00);
        idle();
        cycle(0, 0, 0, 0, 1, 8'h00);

        // Full with simultaneous push/pop, then 20 pairs across the pointer wrap.
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0, 8'(8'h30 + i));
        cycle(0, 0, 1, 1, 0, 8'h99);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, 1, 0, 8'(8'h40 + i));
        idle();

        // Flush at count 5 with a push in the same cycle.
        cycle(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0, 8'(8'h60 + i));
        cycle(0, 1, 1, 1, 0, 8'h77);
        idle();

        // Reset mid-stream with a MODE 1 read in flight.
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 8'(8'h80 + i));
        cycle(0, 0, 0, 1, 0, 8'h00);
        cycle(0, 0, 1, 1, 0, 8'h90);
        cycle(1, 0, 1, 1, 0, 8'h91);
        cycle(1, 0, 1, 1, 1, 8'h92);
        chk("mid reset valid", 32'(valid), 32'd0);
        chk("mid reset rdata mode1", 32'(rdata[1]), 32'd0);
        idle();

        // Randomised phases alternating between fill-biased and drain-biased traffic.
        for (int i = 0; i < 800; i++) begin
            bit fill;
            fill = ((i / 40) % 2) == 0;
            cycle($urandom_range(399) == 0, $urandom_range(99) < 2,
                  $urandom_range(99) < (fill ? 75 : 35), $urandom_range(99) < (fill ? 35 : 75),
                  $urandom_range(99) < 8, 8'($urandom));
        end

        repeat (3) idle();
        chk("scoreboard drained mode0", 32'(eq0.size()), 32'd0);
        chk("scoreboard drained mode1", 32'(eq1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
